// File: rtl/add_sub_regslice_fifo.sv
// Register slice for the add_sub AXI-Stream datapath: Depth-entry circular
// buffer with registered valid/ready, occupancy, almost-full and flush.
module add_sub_regslice_fifo #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned Depth       = 2,
  parameter int unsigned AFullThresh = Depth - 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic [DataWidth-1:0]         data_in,
  input  logic                         vld_in,
  output logic                         ack_in,
  output logic [DataWidth-1:0]         data_out,
  output logic                         vld_out,
  input  logic                         ack_out,
  input  logic                         flush,
  output logic [$clog2(Depth+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         apdone_blk
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic                 push;
  logic                 pop;
  logic [CntW-1:0]      count_nxt;

  // Handshakes and next occupancy; flush discards everything, including a
  // same-cycle push, and ignores ack_out.
  always_comb begin
    push      = vld_in & ack_in;
    pop       = vld_out & ack_out;
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + CntW'(1);
        2'b01:   count_nxt = count - CntW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Control state; ready/valid/almost-full are all derived from the next
  // occupancy so they move on the same edge as count.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ack_in      <= 1'b0;
      vld_out     <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      count       <= count_nxt;
      ack_in      <= (count_nxt < CntW'(Depth));
      vld_out     <= (count_nxt != '0);
      almost_full <= (count_nxt >= CntW'(AFullThresh));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PtrW'(1);
        if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      end
    end
  end

  // Payload storage; not reset, written only on an accepted, unflushed push.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst && !flush && push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  assign data_out   = mem[rd_ptr];
  assign apdone_blk = (count >= CntW'(2)) | ((count != '0) & ~ack_out);

endmodule

// File: tb/tb_add_sub_regslice_fifo.sv
// Directed bench for add_sub_regslice_fifo: a Depth=4 instance for the
// streaming/fill/flush/reset sequences and a Depth=2 instance for wrap-around.
module tb_add_sub_regslice_fifo;

  logic        ap_clk = 1'b0;
  logic        ap_rst;

  logic [31:0] data_in_a, data_out_a;
  logic        vld_in_a, ack_in_a, vld_out_a, ack_out_a, flush_a;
  logic [2:0]  count_a;
  logic        af_a, apdone_a;

  logic [31:0] data_in_b, data_out_b;
  logic        vld_in_b, ack_in_b, vld_out_b, ack_out_b, flush_b;
  logic [1:0]  count_b;
  logic        af_b, apdone_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ap_clk = ~ap_clk;

  add_sub_regslice_fifo #(.DataWidth(32), .Depth(4), .AFullThresh(3)) u_a (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .data_in(data_in_a), .vld_in(vld_in_a), .ack_in(ack_in_a),
    .data_out(data_out_a), .vld_out(vld_out_a), .ack_out(ack_out_a),
    .flush(flush_a), .count(count_a), .almost_full(af_a), .apdone_blk(apdone_a)
  );

  add_sub_regslice_fifo #(.DataWidth(32), .Depth(2), .AFullThresh(1)) u_b (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .data_in(data_in_b), .vld_in(vld_in_b), .ack_in(ack_in_b),
    .data_out(data_out_b), .vld_out(vld_out_b), .ack_out(ack_out_b),
    .flush(flush_b), .count(count_b), .almost_full(af_b), .apdone_blk(apdone_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, ".vld_out"}, 64'(vld_out_a), 64'd0);
    chk({tag, ".ack_in"},  64'(ack_in_a),  64'd0);
    chk({tag, ".count"},   64'(count_a),   64'd0);
    chk({tag, ".af"},      64'(af_a),      64'd0);
    chk({tag, ".apdone"},  64'(apdone_a),  64'd0);
  endtask

  // Watchdog: never hang.
  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] nxt;
    logic        pu, po;
    int          xfers, cyc, exp_cnt;

    ap_rst = 1'b1;
    data_in_a = '0; vld_in_a = 1'b0; ack_out_a = 1'b0; flush_a = 1'b0;
    data_in_b = '0; vld_in_b = 1'b0; ack_out_b = 1'b0; flush_b = 1'b0;

    // Reset, then idle
    tick(); tick(); tick();
    chk_reset_a("rst");
    ap_rst = 1'b0;
    #1;
    chk("rel.ack_in_cycle1", 64'(ack_in_a), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle.ack_in",  64'(ack_in_a),  64'd1);
      chk("idle.vld_out", 64'(vld_out_a), 64'd0);
      chk("idle.count",   64'(count_a),   64'd0);
      chk("idle.apdone",  64'(apdone_a),  64'd0);
    end

    // Streaming: back-to-back with downstream always ready
    ack_out_a = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      vld_in_a = 1'b1; data_in_a = 32'(i);
      tick();
      chk("str.vld_out",  64'(vld_out_a),  64'd1);
      chk("str.data_out", 64'(data_out_a), 64'(i));
      chk("str.count",    64'(count_a),    64'd1);
      chk("str.ack_in",   64'(ack_in_a),   64'd1);
    end
    vld_in_a = 1'b0;
    tick();
    chk("str.end.count", 64'(count_a), 64'd0);
    chk("str.end.vld",   64'(vld_out_a), 64'd0);

    // Fill and stall: only four of six words accepted
    ack_out_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vld_in_a = 1'b1; data_in_a = 32'hA0 + 32'(i);
      tick();
      exp_cnt = (i + 1 > 4) ? 4 : i + 1;
      chk("fill.count",  64'(count_a),   64'(exp_cnt));
      chk("fill.ack_in", 64'(ack_in_a),  64'(exp_cnt < 4));
      chk("fill.af",     64'(af_a),      64'(exp_cnt >= 3));
      chk("fill.apdone", 64'(apdone_a),  64'd1);
      chk("fill.data",   64'(data_out_a), 64'hA0);
    end
    vld_in_a = 1'b0;
    ack_out_a = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("drain.data", 64'(data_out_a), 64'hA0 + 64'(j));
      chk("drain.apdone", 64'(apdone_a), 64'(4 - j >= 2));
      tick();
      chk("drain.count",  64'(count_a),   64'(3 - j));
      chk("drain.ack_in", 64'(ack_in_a),  64'd1);
      chk("drain.vld",    64'(vld_out_a), 64'(j < 3));
    end

    // Flush with a same-cycle push of 0xFF
    ack_out_a = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      vld_in_a = 1'b1; data_in_a = 32'h11 * 32'(i);
      tick();
    end
    vld_in_a = 1'b0;
    chk("fl.pre.count", 64'(count_a), 64'd3);
    flush_a = 1'b1; vld_in_a = 1'b1; data_in_a = 32'hFF; ack_out_a = 1'b1;
    tick();
    flush_a = 1'b0; vld_in_a = 1'b0; ack_out_a = 1'b0;
    chk("fl.count",  64'(count_a),   64'd0);
    chk("fl.vld",    64'(vld_out_a), 64'd0);
    chk("fl.ack_in", 64'(ack_in_a),  64'd1);
    chk("fl.af",     64'(af_a),      64'd0);
    vld_in_a = 1'b1; data_in_a = 32'h55;
    tick();
    vld_in_a = 1'b0;
    chk("fl.post.vld",   64'(vld_out_a),  64'd1);
    chk("fl.post.data",  64'(data_out_a), 64'h55);
    chk("fl.post.count", 64'(count_a),    64'd1);
    ack_out_a = 1'b1;
    tick();
    ack_out_a = 1'b0;
    chk("fl.post.drain", 64'(count_a), 64'd0);

    // Reset mid-stream with two entries held
    vld_in_a = 1'b1; data_in_a = 32'h66; tick();
    data_in_a = 32'h77; tick();
    vld_in_a = 1'b0;
    chk("mr.pre.count", 64'(count_a), 64'd2);
    ap_rst = 1'b1;
    tick();
    chk_reset_a("mr");
    ap_rst = 1'b0;
    tick();
    chk("mr.rel.vld",    64'(vld_out_a), 64'd0);
    chk("mr.rel.count",  64'(count_a),   64'd0);
    chk("mr.rel.ack_in", 64'(ack_in_a),  64'd1);
    vld_in_a = 1'b1; data_in_a = 32'h88;
    tick();
    vld_in_a = 1'b0;
    chk("mr.new.data",  64'(data_out_a), 64'h88);
    chk("mr.new.count", 64'(count_a),    64'd1);
    ack_out_a = 1'b1;
    tick();
    ack_out_a = 1'b0;
    chk("mr.new.empty", 64'(vld_out_a), 64'd0);

    // Wrap-around on the Depth=2 instance with random handshakes
    nxt = 32'hB000_0000;
    xfers = 0;
    cyc = 0;
    while (xfers < 20 && cyc < 400) begin
      vld_in_b  = 1'($urandom_range(0, 1));
      ack_out_b = 1'($urandom_range(0, 1));
      data_in_b = nxt;
      #1;
      chk("wr.vld",    64'(vld_out_b), 64'(q.size() != 0));
      chk("wr.ack_in", 64'(ack_in_b),  64'(q.size() < 2));
      chk("wr.apdone", 64'(apdone_b),
          64'((q.size() >= 2) || ((q.size() != 0) && !ack_out_b)));
      if (q.size() != 0) chk("wr.data", 64'(data_out_b), 64'(q[0]));
      pu = vld_in_b & (q.size() < 2);
      po = ack_out_b & (q.size() != 0);
      tick();
      if (po) begin
        void'(q.pop_front());
        xfers++;
      end
      if (pu) begin
        q.push_back(nxt);
        nxt = nxt + 32'd1;
      end
      chk("wr.count", 64'(count_b), 64'(q.size()));
      cyc++;
    end
    chk("wr.done", 64'(xfers >= 20), 64'd1);
    vld_in_b = 1'b0; ack_out_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/add_sub_regslice_fifo.md
# add_sub_regslice_fifo

Parametrised register slice for the add_sub AXI-Stream datapath: a Depth-entry circular buffer with fully registered valid/ready in both directions, occupancy reporting, a programmable almost-full flag and a synchronous flush. It sits between the HLS core's stream ports and the outer stream interfaces. Depth=2 reproduces the two-entry "both" slice's handshake and apdone_blk behaviour. Larger depths absorb downstream stalls without a combinational ready path.

## Interface
Parameters:
- DataWidth, 32, payload width in bits (>=1)
- Depth, 2, number of entries; power of two, >=2
- AFullThresh, Depth-1, almost_full asserts when count >= AFullThresh; legal range 1..Depth

Ports:
- ap_clk  in  1  single clock; all state updates on rising edge
- ap_rst  in  1  reset, synchronous, active-high
- data_in  in  DataWidth  upstream payload
- vld_in  in  1  upstream valid
- ack_in  out  1  upstream ready; registered
- data_out  out  DataWidth  downstream payload; muxed from storage registers only
- vld_out  out  1  downstream valid; registered
- ack_out  in  1  downstream ready
- flush  in  1  synchronous discard of all stored entries
- count  out  $clog2(Depth+1)  current occupancy; registered
- almost_full  out  1  count >= AFullThresh; registered
- apdone_blk  out  1  slice is holding data that will not drain this cycle

## Operation
- Storage: Depth registers, write pointer wr_ptr and read pointer rd_ptr, each $clog2(Depth) bits, wrapping modulo Depth. Payload registers are not reset.
- Push = vld_in & ack_in. Pop = vld_out & ack_out.
- Push: mem[wr_ptr] <= data_in, wr_ptr++.
- Pop: rd_ptr++.
- count update: count + push - pop. Simultaneous push and pop leaves count unchanged.
- ack_in: registered. Next value is 1 iff next count < Depth. It does not depend combinationally on ack_out. When full, a same-cycle pop does not enable a same-cycle push.
- vld_out = (count != 0). data_out = mem[rd_ptr]. Both are stable while vld_out & ~ack_out.
- Flush (flush=1, ap_rst=0):
  - count, wr_ptr and rd_ptr go to 0.
  - Any same-cycle push is discarded and ack_out is ignored.
  - Next cycle: vld_out=0, ack_in=1, almost_full=0.
- apdone_blk = (count >= 2) | (count != 0 & ~ack_out). This is combinational on ack_out.
- Reset has priority over flush. Flush has priority over push and pop.

## Timing
- Reset values while ap_rst=1:
  - vld_out=0, ack_in=0, count=0, almost_full=0, apdone_blk=0.
  - Pointers are 0. data_out is don't-care.
- First cycle after reset deasserts: ack_in=0. From the second cycle on, ack_in=1. This matches the two-entry slice's state-0 start-up.
- Reset asserted mid-operation: all stored data is lost. Outputs take reset values on the next edge.
- Latency: a push at edge N makes vld_out=1 with that data from edge N onward. That is one cycle from vld_in sampled to vld_out. There is no bypass path.
- Throughput: one transfer per cycle in steady state when 0 < count < Depth.
- Full (count=Depth):
  - ack_in=0.
  - A pop at edge N gives count=Depth-1 and ack_in=1 after edge N.
  - Throughput is 1 per 2 cycles only if the slice oscillates at full.
- Empty: vld_out=0, and ack_out is ignored.
- almost_full and ack_in are updated at the same edge as count.

## Test plan
- Reset then idle: hold vld_in=0 for 5 cycles. Required: ack_in=0 in cycle 1 after reset, then 1. vld_out, count and apdone_blk stay 0.
- Streaming, Depth=4: ack_out=1, push 0x00000001..0x00000010 back-to-back. Required:
  - data_out sequence 1..16 in order, each valid one cycle after its push.
  - count stays at 1 and ack_in stays 1.
- Fill and stall, Depth=4, AFullThresh=3: ack_out=0, push 0xA0..0xA5. Required:
  - Only 0xA0..0xA3 accepted; ack_in=0 after the 4th push.
  - almost_full=1 from count=3; count=4.
  - apdone_blk=1 from count=1.
  - Then ack_out=1 drains 0xA0..0xA3 in order, and ack_in returns 1 one cycle after the first pop.
- Wrap-around, Depth=2: 20 transfers with random vld_in and ack_out. Required:
  - Output order matches input order.
  - No duplicated or dropped word across pointer wrap.
  - apdone_blk matches the formula every cycle.
- Flush: with count=3, assert flush together with vld_in=1, data 0xFF. Required:
  - Next cycle count=0 and vld_out=0.
  - 0xFF is never output.
  - A subsequent push of 0x55 appears as the next data_out.
- Reset mid-stream: assert ap_rst with count=2. Required:
  - Next cycle all outputs are at reset values.
  - After release, the old data never appears.
